// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V opcode and funct3 constants plus store entry layout
package riscv_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;

  localparam logic [2:0] F3_B = 3'b000;
  localparam logic [2:0] F3_H = 3'b001;
  localparam logic [2:0] F3_W = 3'b010;

  // One buffered store: word address, lane-replicated data, byte strobes
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } store_entry_t;

  localparam int STORE_ENTRY_W = $bits(store_entry_t);

endpackage

// File: rtl/store_fifo.sv
// rtl/store_fifo.sv - power-of-two store buffer with head data masked to zero when empty
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; stale contents are harmless because the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - formats SB/SH/SW stores into strobed words and buffers them toward memory
module store_unit
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        store_err,
  output logic        empty
);

  logic         full;
  logic         accept;
  logic         misaligned;
  logic         illegal;
  logic         push;
  logic [31:0]  fmt_wdata;
  logic [3:0]   fmt_wstrb;
  store_entry_t in_entry;
  store_entry_t head_entry;

  assign req_ready = ~full;
  assign mem_valid = ~empty;
  assign accept    = req_valid & req_ready & (opcode == OPC_STORE);
  assign push      = accept & ~misaligned & ~illegal;

  // Replicate the source bytes across every lane and pick strobes from the low address bits
  always_comb begin
    fmt_wdata  = '0;
    fmt_wstrb  = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        fmt_wdata = {4{store_data[7:0]}};
        fmt_wstrb = 4'b0001 << addr[1:0];
      end
      F3_H: begin
        fmt_wdata  = {2{store_data[15:0]}};
        fmt_wstrb  = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
      end
      F3_W: begin
        fmt_wdata  = store_data;
        fmt_wstrb  = 4'b1111;
        misaligned = (addr[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign in_entry.addr  = {addr[31:2], 2'b00};
  assign in_entry.wdata = fmt_wdata;
  assign in_entry.wstrb = fmt_wstrb;

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (STORE_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_entry),
    .pop   (mem_ready),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  assign mem_addr  = head_entry.addr;
  assign mem_wdata = head_entry.wdata;
  assign mem_wstrb = head_entry.wstrb;

  // Dropped stores raise a single-cycle error flag on the following cycle
  always_ff @(posedge clk) begin
    if (!rst_n) store_err <= 1'b0;
    else        store_err <= accept & (misaligned | illegal);
  end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed vector table plus randomized queue-model comparison for store_unit
module tb_store_unit;

  localparam int DEPTH = 2;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] LD = 7'b0000011;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        store_err;
  logic        empty;

  int n_checks;
  int n_pass;

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .store_err  (store_err),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic        mr;
    logic        mv;
    logic [31:0] ma;
    logic [31:0] mw;
    logic [3:0]  ms;
    logic        err;
    logic        rdy;
    logic        emp;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
  } ent_t;

  vec_t tbl[$];
  ent_t q[$];
  logic m_err;

  function automatic vec_t mk(logic r, logic v, logic [6:0] op, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] d, logic mr,
                              logic mv, logic [31:0] ma, logic [31:0] mw, logic [3:0] ms,
                              logic err, logic rdy, logic emp);
    vec_t x;
    x.rst_n = r; x.v = v; x.op = op; x.f3 = f3; x.a = a; x.d = d; x.mr = mr;
    x.mv = mv; x.ma = ma; x.mw = mw; x.ms = ms; x.err = err; x.rdy = rdy; x.emp = emp;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic mr);
    rst_n = r; req_valid = v; opcode = op; funct3 = f3;
    addr = a; store_data = d; mem_ready = mr;
  endtask

  // Reference: a store of n bytes lands in lanes [a%4, a%4+n), each lane carrying byte (lane % n) of the source
  task automatic model_step(input logic r, input logic v, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d, input logic mr);
    int   n;
    int   off;
    logic acc;
    logic bad;
    logic do_pop;
    ent_t e;
    if (!r) begin
      q.delete();
      m_err = 1'b0;
      return;
    end
    n   = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    off = int'(a % 4);
    acc = v && (q.size() < DEPTH) && (op == ST);
    bad = (n == 0) || ((a % n) != 0);
    do_pop = (q.size() > 0) && mr;
    e.a = a & 32'hFFFF_FFFC;
    e.w = '0;
    e.s = '0;
    if (n != 0) begin
      for (int i = 0; i < 4; i++) begin
        e.w[8*i +: 8] = d[8*(i % n) +: 8];
        e.s[i] = (i >= off) && (i < off + n);
      end
    end
    if (do_pop) void'(q.pop_front());
    if (acc && !bad) q.push_back(e);
    m_err = acc && bad;
  endtask

  task automatic check_model();
    chk("rnd_mem_valid", 32'(mem_valid), 32'(q.size() > 0));
    chk("rnd_mem_addr",  mem_addr,  (q.size() > 0) ? q[0].a : 32'h0);
    chk("rnd_mem_wdata", mem_wdata, (q.size() > 0) ? q[0].w : 32'h0);
    chk("rnd_mem_wstrb", 32'(mem_wstrb), (q.size() > 0) ? 32'(q[0].s) : 32'h0);
    chk("rnd_store_err", 32'(store_err), 32'(m_err));
    chk("rnd_req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
    chk("rnd_empty",     32'(empty), 32'(q.size() == 0));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_err    = 1'b0;
    drive(1'b0, 1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 1'b0);

    //             rst v  op  f3    addr          data          mr   mv ma            mw            ms       err rdy emp
    tbl.push_back(mk(0, 0, ST, 3'd0, 32'h0,        32'h0,        0,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, ST, 3'd0, 32'h1003,     32'hAABBCCDD, 0,   1, 32'h1000,     32'hDDDDDDDD, 4'b1000, 0, 1, 0));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, ST, 3'd1, 32'h2002,     32'h12345678, 1,   1, 32'h2000,     32'h56785678, 4'b1100, 0, 1, 0));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h3001,     32'h55555555, 0,   0, 32'h0,        32'h0,        4'h0,    1, 1, 1));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        0,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, ST, 3'd3, 32'h3000,     32'h55555555, 0,   0, 32'h0,        32'h0,        4'h0,    1, 1, 1));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        0,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h4000,     32'h11111111, 0,   1, 32'h4000,     32'h11111111, 4'hF,    0, 1, 0));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h4004,     32'h22222222, 0,   1, 32'h4000,     32'h11111111, 4'hF,    0, 0, 0));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h4008,     32'h33333333, 0,   1, 32'h4000,     32'h11111111, 4'hF,    0, 0, 0));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h4008,     32'h33333333, 1,   1, 32'h4004,     32'h22222222, 4'hF,    0, 1, 0));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h4008,     32'h33333333, 1,   1, 32'h4008,     32'h33333333, 4'hF,    0, 1, 0));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, ST, 3'd0, 32'h5001,     32'h000000AB, 1,   1, 32'h5000,     32'hABABABAB, 4'b0010, 0, 1, 0));
    tbl.push_back(mk(1, 1, ST, 3'd1, 32'h5006,     32'h0000BEEF, 1,   1, 32'h5004,     32'hBEEFBEEF, 4'b1100, 0, 1, 0));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h5008,     32'hCAFEF00D, 0,   1, 32'h5004,     32'hBEEFBEEF, 4'b1100, 0, 0, 0));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        0,   1, 32'h5004,     32'hBEEFBEEF, 4'b1100, 0, 0, 0));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        1,   1, 32'h5008,     32'hCAFEF00D, 4'hF,    0, 1, 0));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        0,   1, 32'h5008,     32'hCAFEF00D, 4'hF,    0, 1, 0));
    tbl.push_back(mk(1, 1, ST, 3'd2, 32'h6000,     32'h66666666, 0,   1, 32'h5008,     32'hCAFEF00D, 4'hF,    0, 0, 0));
    tbl.push_back(mk(0, 1, ST, 3'd2, 32'h7000,     32'h77777777, 1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h0,        32'h0,        1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, LD, 3'd2, 32'h8000,     32'h88888888, 1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 1, LD, 3'd2, 32'h8001,     32'h88888888, 1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));
    tbl.push_back(mk(1, 0, ST, 3'd0, 32'h9000,     32'h99999999, 1,   0, 32'h0,        32'h0,        4'h0,    0, 1, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].v, tbl[i].op, tbl[i].f3, tbl[i].a, tbl[i].d, tbl[i].mr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_mem_valid", i), 32'(mem_valid), 32'(tbl[i].mv));
      chk($sformatf("vec%0d_mem_addr", i),  mem_addr,  tbl[i].ma);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, tbl[i].mw);
      chk($sformatf("vec%0d_mem_wstrb", i), 32'(mem_wstrb), 32'(tbl[i].ms));
      chk($sformatf("vec%0d_store_err", i), 32'(store_err), 32'(tbl[i].err));
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_empty", i),     32'(empty), 32'(tbl[i].emp));
    end

    // Randomized phase: start from reset so the model and DUT agree on state
    drive(1'b0, 1'b0, ST, 3'd0, 32'h0, 32'h0, 1'b0);
    model_step(1'b0, 1'b0, ST, 3'd0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check_model();

    for (int c = 0; c < 600; c++) begin
      logic        r;
      logic        v;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
      logic        mr;
      r  = ($urandom_range(0, 79) != 0);
      v  = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? LD : 7'($urandom)) : ST;
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      d  = $urandom;
      mr = ($urandom_range(0, 2) != 0);
      drive(r, v, op, f3, a, d, mr);
      model_step(r, v, op, f3, a, d, mr);
      @(posedge clk);
      #1;
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
